// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S transmitter.
// Holds the FSM state enum, word-select encodings, parameter range limits
// and the debug observation struct exported by the core.
package i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Word-select levels (Philips I2S: low = left slot, high = right slot)
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Legal parameter ranges
    localparam int DATA_W_MIN  = 8;
    localparam int DATA_W_MAX  = 32;
    localparam int SCK_DIV_MIN = 1;
    localparam int SCK_DIV_MAX = 256;

    // Bit counter width that covers the widest legal frame (2*DATA_W_MAX bits)
    localparam int DBG_CNT_W = $clog2(2 * DATA_W_MAX);

    // Debug view of the core: FSM state, frame bit counter, SCK edge strobes
    typedef struct packed {
        state_t                 state;
        logic [DBG_CNT_W-1:0]   bit_cnt;
        logic                   sck_rise;
        logic                   sck_fall;
    } dbg_t;

    // Number of bits in one stereo frame
    function automatic int frame_bits(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// i2s_tx_clkgen: SCK generator for the I2S transmitter.
// While run_i is high the divider counts clk_i cycles and toggles sck_o every
// SCK_DIV cycles; the first toggle is a rising edge. While run_i is low the
// divider and sck_o are held at 0. sck_rise_o / sck_fall_o are high on the
// clk_i cycle whose closing edge makes SCK rise / fall, so registers enabled by
// them change on exactly that SCK edge.
module i2s_tx_clkgen
    import i2s_pkg::*;
#(
    parameter int SCK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic sck_o,
    output logic sck_rise_o,
    output logic sck_fall_o
);

    // Divider sized for the largest legal SCK_DIV (counts 0..SCK_DIV-1)
    localparam int                 DIV_W    = $clog2(SCK_DIV_MAX);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_sck;
    logic             w_tick;

    assign w_tick     = run_i && (r_div == DIV_LAST);
    assign sck_o      = r_sck;
    assign sck_rise_o = w_tick && !r_sck;
    assign sck_fall_o = w_tick && r_sck;

    // Divider and SCK level: held at 0 outside RUN, toggle on divider terminal count
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (!run_i) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_div <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx_core.sv
// i2s_tx_core: Philips I2S stereo transmitter with a one-pair holding register.
// A {left,right} pair is accepted on valid&ready into the holding register and
// moved into a 2*DATA_W shift register at each frame start (SCK falling edge
// where the bit counter wraps to 0). Data and WS change on SCK falling edges,
// MSB first, with WS leading each slot's MSB by one SCK.
// Build option: I2S_TX_UNDERRUN_REPEAT_EN -- when defined, a frame that starts
// with the holding register empty resends the previous pair; otherwise zeros.
//
// Handshake: s_ready_o is high whenever the holding register is empty; a pair
// transfers on the clk_i edge where s_valid_i and s_ready_o are both high, and
// s_valid_i / data must stay stable until that edge. If the transfer edge is
// also a frame-start edge with the register empty, the pair goes straight into
// the shift register and the holding register stays empty.
module i2s_tx_core
    import i2s_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SCK_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] s_left_i,
    input  logic [DATA_W-1:0] s_right_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              sck_o,
    output logic              ws_o,
    output logic              sd_o,
    output logic              underrun_o,
    output dbg_t              dbg_o
);

    localparam int                 FRAME_W  = frame_bits(DATA_W);
    localparam int                 CNT_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]   CNT_WS_R = CNT_W'(DATA_W - 1);

    // FSM
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_run;

    // SCK generator strobes
    logic               w_sck;
    logic               w_sck_rise;
    logic               w_sck_fall;

    // Bit sequencing
    logic               r_first;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ws;
    logic               w_wrap;
    logic               w_load;

    // Data path
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] r_hold;
    logic               r_full;
    logic               r_underrun;
    logic [FRAME_W-1:0] w_pair_in;
    logic [FRAME_W-1:0] w_frame;
    logic [FRAME_W-1:0] w_fallback;
    logic               w_accept;
    logic               w_underrun;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [FRAME_W-1:0] r_last;
    assign w_fallback = r_last;
`else
    assign w_fallback = '0;
`endif

    assign w_run = (r_state == RUN);

    i2s_tx_clkgen #(
        .SCK_DIV    (SCK_DIV)
    ) u_clkgen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .run_i      (w_run),
        .sck_o      (w_sck),
        .sck_rise_o (w_sck_rise),
        .sck_fall_o (w_sck_fall)
    );

    // Frame-boundary decode, holding-register handshake and frame source select
    always_comb begin
        w_pair_in  = {s_left_i, s_right_i};
        w_accept   = s_valid_i && !r_full;
        // The first falling edge after entering RUN starts the first frame;
        // afterwards a frame starts when the counter wraps from its last value.
        w_wrap     = w_sck_fall && (r_first || (r_cnt == CNT_LAST));
        // A wrap with en_i low ends transmission instead of starting a frame
        w_load     = w_wrap && (r_first || en_i);
        w_underrun = w_load && !r_full && !w_accept;
        w_cnt_nxt  = w_wrap ? '0 : (r_cnt + CNT_W'(1));
        if (r_full) begin
            w_frame = r_hold;
        end else if (w_accept) begin
            w_frame = w_pair_in;
        end else begin
            w_frame = w_fallback;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave RUN only at a frame boundary so frames always complete
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_wrap && !r_first && !en_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bit counter and word select, advanced on SCK falling edges
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_first <= 1'b1;
            r_cnt   <= '0;
            r_ws    <= WS_LEFT;
        end else if (!w_run) begin
            r_first <= 1'b1;
            r_cnt   <= '0;
            r_ws    <= WS_LEFT;
        end else if (w_sck_fall) begin
            r_first <= 1'b0;
            r_cnt   <= w_cnt_nxt;
            // WS switches while the last bit of the previous slot is on the line
            if (w_cnt_nxt == CNT_WS_R) begin
                r_ws <= WS_RIGHT;
            end else if (w_cnt_nxt == CNT_LAST) begin
                r_ws <= WS_LEFT;
            end
        end
    end

    // Output shift register: load a frame at frame start, else shift MSB-first
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_shift <= '0;
        end else if (!w_run) begin
            r_shift <= '0;
        end else if (w_sck_fall) begin
            if (w_load) begin
                r_shift <= w_frame;
            end else begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end
        end
    end

    // Holding register, underrun pulse and (optionally) last-sent pair
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_hold     <= '0;
            r_full     <= 1'b0;
            r_underrun <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            r_last     <= '0;
`endif
        end else begin
            r_underrun <= w_underrun;
            if (w_load) begin
                r_full <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                r_last <= w_frame;
`endif
            end else if (w_accept) begin
                r_hold <= w_pair_in;
                r_full <= 1'b1;
            end
        end
    end

    assign s_ready_o  = !r_full;
    assign sck_o      = w_sck;
    assign ws_o       = r_ws;
    assign sd_o       = r_shift[FRAME_W-1];
    assign underrun_o = r_underrun;

    assign dbg_o.state    = r_state;
    assign dbg_o.bit_cnt  = DBG_CNT_W'(r_cnt);
    assign dbg_o.sck_rise = w_sck_rise;
    assign dbg_o.sck_fall = w_sck_fall;

endmodule

// File: tb/tb_i2s_tx_core.sv
// tb_i2s_tx_core: self-checking bench for i2s_tx_core (DATA_W=16, SCK_DIV=2).
// Acts as an I2S receiver: samples sd_o/ws_o on every SCK rising edge and
// rebuilds frames, which are compared with pairs expected from the stimulus.
module tb_i2s_tx_core;
    import i2s_pkg::*;

    localparam int DW     = 16;
    localparam int DIV    = 2;
    localparam int FW     = 2 * DW;
    localparam int PER    = 2 * DIV;
    localparam int BUDGET = 200;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b0;
    logic          valid  = 1'b0;
    logic [DW-1:0] left   = '0;
    logic [DW-1:0] right  = '0;
    logic          ready;
    logic          sck;
    logic          ws;
    logic          sd;
    logic          und;
    dbg_t          dbg;

    int errors  = 0;
    int checks  = 0;
    int n_under = 0;

    logic [FW-1:0] exp_q[$];

    i2s_tx_core #(
        .DATA_W     (DW),
        .SCK_DIV    (DIV)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .en_i       (en),
        .s_left_i   (left),
        .s_right_i  (right),
        .s_valid_i  (valid),
        .s_ready_o  (ready),
        .sck_o      (sck),
        .ws_o       (ws),
        .sd_o       (sd),
        .underrun_o (und),
        .dbg_o      (dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (und) n_under++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: WS carries the slot of the NEXT bit, so bit i (0 = left MSB)
    // is sent with ws = 1 when bit i+1 (mod frame) belongs to the right slot.
    function automatic logic [FW-1:0] ws_model();
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < FW; i++) v[FW-1-i] = (((i + 1) % FW) >= DW);
        return v;
    endfunction

    // Underrun frame content: zeros, or the previous pair in repeat builds
    function automatic logic [FW-1:0] underrun_frame(input logic [FW-1:0] prev);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        return prev;
`else
        return (prev & '0);
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = ready;
        if (ok) begin
            left  = l;
            right = r;
            valid = 1'b1;
            @(posedge clk);
            #1;
            valid = 1'b0;
        end
    endtask

    // Wait for the next SCK rising edge (sampled on clk falling edges)
    task automatic wait_rise(output int waited, output logic b_sd, output logic b_ws);
        logic prev;
        bit   seen;
        prev   = sck;
        waited = 0;
        seen   = 0;
        b_sd   = 1'b0;
        b_ws   = 1'b0;
        while (!seen && waited < BUDGET) begin
            @(negedge clk);
            waited++;
            if (sck && !prev) begin
                seen = 1;
                b_sd = sd;
                b_ws = ws;
            end
            prev = sck;
        end
    endtask

    // Receive one frame; optionally drop en_i right after bit drop_at
    task automatic capture_frame(input int drop_at, output logic [FW-1:0] bits,
                                 output logic [FW-1:0] wsb, output int bad, output int cyc);
        int   w;
        logic b_sd, b_ws;
        bits = '0;
        wsb  = '0;
        bad  = 0;
        cyc  = 0;
        for (int i = 0; i < FW; i++) begin
            wait_rise(w, b_sd, b_ws);
            bits[FW-1-i] = b_sd;
            wsb[FW-1-i]  = b_ws;
            if (w != PER) bad++;
            cyc += w;
            if (i == drop_at) en = 1'b0;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (dbg.state != IDLE && n < 8 * PER) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        valid = 1'b1;
        left  = DW'($urandom);
        right = DW'($urandom);
        repeat (3) @(negedge clk);
        checks++; if (sck !== 1'b0)   $display("FAIL reset_sck: got %b want 0", sck);   if (sck !== 1'b0)   errors++;
        checks++; if (ws !== 1'b0)    begin $display("FAIL reset_ws: got %b want 0", ws); errors++; end
        checks++; if (sd !== 1'b0)    begin $display("FAIL reset_sd: got %b want 0", sd); errors++; end
        checks++; if (und !== 1'b0)   begin $display("FAIL reset_underrun: got %b want 0", und); errors++; end
        checks++; if (ready !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", ready); errors++; end
        checks++; if (dbg.state !== IDLE) begin $display("FAIL reset_state: got %0d want IDLE", dbg.state); errors++; end
        rst_n = 1'b1;
        en    = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin $display("FAIL reset_no_accept: ready %b want 1", ready); errors++; end
    endtask

    int under_base;
    logic [FW-1:0] single_pair;

    task automatic test_single_frame();
        logic [FW-1:0] bits, wsb;
        int   bad, cyc, w;
        logic b_sd, b_ws;
        bit   ok;
        do_reset();
        under_base  = n_under;
        single_pair = {16'hA5C3, 16'h0F0F};
        send_pair(16'hA5C3, 16'h0F0F, ok);
        @(negedge clk);
        checks++; if (!ok || ready !== 1'b0) begin $display("FAIL single_accept: ok %0d ready %b want ready 0", ok, ready); errors++; end
        en = 1'b1;
        wait_rise(w, b_sd, b_ws);
        checks++; if (w != DIV + 1) begin $display("FAIL single_first_rise: %0d cycles want %0d", w, DIV + 1); errors++; end
        checks++; if (b_sd !== 1'b0 || b_ws !== 1'b0) begin $display("FAIL single_leadin: sd %b ws %b want 0 0", b_sd, b_ws); errors++; end
        capture_frame(-1, bits, wsb, bad, cyc);
        checks++; if (bits !== single_pair) begin $display("FAIL single_data: got %h want %h", bits, single_pair); errors++; end
        checks++; if (wsb !== ws_model()) begin $display("FAIL single_ws: got %h want %h", wsb, ws_model()); errors++; end
        checks++; if (bad != 0) begin $display("FAIL single_sck_period: %0d periods not %0d clk", bad, PER); errors++; end
        checks++; if (ready !== 1'b1) begin $display("FAIL single_ready_after_load: got %b want 1", ready); errors++; end
        checks++; if (n_under != under_base) begin $display("FAIL single_no_underrun: %0d pulses want 0", n_under - under_base); errors++; end
    endtask

    task automatic test_underrun();
        logic [FW-1:0] bits, wsb, expf;
        int bad, cyc, n, hi;
        expf = underrun_frame(single_pair);
        capture_frame(5, bits, wsb, bad, cyc);
        checks++; if (bits !== expf) begin $display("FAIL underrun_data: got %h want %h", bits, expf); errors++; end
        checks++; if (wsb !== ws_model()) begin $display("FAIL underrun_ws: got %h want %h", wsb, ws_model()); errors++; end
        checks++; if (n_under - under_base != 1) begin $display("FAIL underrun_pulses: got %0d want 1", n_under - under_base); errors++; end
        wait_idle(n);
        checks++; if (n > PER) begin $display("FAIL stop_idle_time: %0d cycles want <= %0d", n, PER); errors++; end
        checks++; if (sck !== 1'b0 || ws !== 1'b0 || sd !== 1'b0) begin $display("FAIL stop_outputs: sck %b ws %b sd %b want 0 0 0", sck, ws, sd); errors++; end
        hi = 0;
        repeat (3 * PER) begin
            @(negedge clk);
            if (sck) hi++;
        end
        checks++; if (hi != 0) begin $display("FAIL stop_sck_quiet: sck high %0d cycles want 0", hi); errors++; end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] l_a[4];
        logic [DW-1:0] r_a[4];
        logic [FW-1:0] bits, wsb, expf;
        int   bad, cyc, w, base, n;
        logic b_sd, b_ws;
        bit   ok;
        do_reset();
        base = n_under;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            l_a[i] = DW'($urandom);
            r_a[i] = DW'($urandom_range(0, 65535));
            exp_q.push_back({l_a[i], r_a[i]});
        end
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send_pair(l_a[i], r_a[i], ok);
                    checks++; if (!ok) begin $display("FAIL b2b_send: pair %0d not accepted", i); errors++; end
                end
            end
            begin
                @(negedge clk);
                en = 1'b1;
                wait_rise(w, b_sd, b_ws);
                checks++; if (b_sd !== 1'b0) begin $display("FAIL b2b_leadin: sd %b want 0", b_sd); errors++; end
                for (int f = 0; f < 4; f++) begin
                    capture_frame((f == 3) ? 5 : -1, bits, wsb, bad, cyc);
                    expf = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    checks++; if (bits !== expf) begin $display("FAIL b2b_data%0d: got %h want %h", f, bits, expf); errors++; end
                    checks++; if (cyc != FW * PER) begin $display("FAIL b2b_frame_len%0d: got %0d clk want %0d", f, cyc, FW * PER); errors++; end
                    checks++; if (wsb !== ws_model()) begin $display("FAIL b2b_ws%0d: got %h want %h", f, wsb, ws_model()); errors++; end
                end
            end
        join
        wait_idle(n);
        checks++; if (n_under != base) begin $display("FAIL b2b_underrun: %0d pulses want 0", n_under - base); errors++; end
        checks++; if (dbg.state !== IDLE || sck !== 1'b0) begin $display("FAIL b2b_stop: state %0d sck %b want IDLE 0", dbg.state, sck); errors++; end
    endtask

    task automatic test_direct_load();
        logic [FW-1:0] bits, wsb, pa, pb;
        int bad, cyc, w, base, n;
        logic b_sd, b_ws;
        bit ok;
        do_reset();
        base = n_under;
        pa = {DW'($urandom), DW'($urandom)};
        pb = {DW'($urandom), DW'($urandom)};
        send_pair(pa[FW-1:DW], pa[DW-1:0], ok);
        @(negedge clk);
        en = 1'b1;
        wait_rise(w, b_sd, b_ws);
        capture_frame(-1, bits, wsb, bad, cyc);
        checks++; if (bits !== pa) begin $display("FAIL direct_first: got %h want %h", bits, pa); errors++; end
        // Present the next pair exactly on the frame-start edge with the register empty
        repeat (DIV - 1) @(negedge clk);
        left  = pb[FW-1:DW];
        right = pb[DW-1:0];
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin $display("FAIL direct_ready: got %b want 1", ready); errors++; end
        capture_frame(5, bits, wsb, bad, cyc);
        checks++; if (bits !== pb) begin $display("FAIL direct_data: got %h want %h", bits, pb); errors++; end
        checks++; if (n_under != base) begin $display("FAIL direct_underrun: %0d pulses want 0", n_under - base); errors++; end
        wait_idle(n);
    endtask

    task automatic test_mid_reset();
        logic [FW-1:0] bits, wsb, p1, p2, expf;
        int bad, cyc, w, n;
        logic b_sd, b_ws;
        bit ok;
        do_reset();
        exp_q.delete();
        p1 = {DW'($urandom), DW'($urandom)};
        p2 = {DW'($urandom), DW'($urandom)};
        send_pair(p1[FW-1:DW], p1[DW-1:0], ok);
        @(negedge clk);
        en = 1'b1;
        wait_rise(w, b_sd, b_ws);
        for (int i = 0; i <= 20; i++) wait_rise(w, b_sd, b_ws);
        checks++; if (b_ws !== 1'b1) begin $display("FAIL midrst_ws_before: got %b want 1", b_ws); errors++; end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (sck !== 1'b0 || ws !== 1'b0 || sd !== 1'b0 || und !== 1'b0) begin
            $display("FAIL midrst_outputs: sck %b ws %b sd %b und %b want 0 0 0 0", sck, ws, sd, und); errors++;
        end
        checks++; if (ready !== 1'b1 || dbg.state !== IDLE) begin $display("FAIL midrst_state: ready %b state %0d want 1 IDLE", ready, dbg.state); errors++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(p2);
        send_pair(p2[FW-1:DW], p2[DW-1:0], ok);
        wait_rise(w, b_sd, b_ws);
        checks++; if (b_sd !== 1'b0 || b_ws !== 1'b0) begin $display("FAIL midrst_leadin: sd %b ws %b want 0 0", b_sd, b_ws); errors++; end
        capture_frame(5, bits, wsb, bad, cyc);
        expf = exp_q.pop_front();
        checks++; if (bits !== expf) begin $display("FAIL midrst_data: got %h want %h", bits, expf); errors++; end
        checks++; if (wsb !== ws_model() || bad != 0) begin $display("FAIL midrst_timing: ws %h want %h bad periods %0d", wsb, ws_model(), bad); errors++; end
        wait_idle(n);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_underrun();
        test_back_to_back();
        test_direct_load();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_core.md
I2S_TX_CORE -- requirements
Module: i2s_tx_core

Interface
REQ-001 Parameter DATA_W, default 16: bits per channel slot, legal range 8..32.
REQ-002 Parameter SCK_DIV, default 2: clk_i cycles per SCK half-period, legal range 1..256.
REQ-003 clk_i  in  1  system clock; every register SHALL be clocked on posedge clk_i.
REQ-004 rst_i  in  1  reset; synchronous, active-low.
REQ-005 en_i  in  1  transmitter enable.
REQ-006 s_left_i  in  DATA_W  left-channel sample, two's complement.
REQ-007 s_right_i  in  DATA_W  right-channel sample, two's complement.
REQ-008 s_valid_i  in  1  sample pair valid.
REQ-009 s_ready_o  out  1  holding register empty; a pair is accepted on the clk_i edge where s_valid_i and s_ready_o are both 1.
REQ-010 sck_o  out  1  I2S serial clock.
REQ-011 ws_o  out  1  word select: 0 = left, 1 = right.
REQ-012 sd_o  out  1  serial data, MSB first.
REQ-013 underrun_o  out  1  one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-014 FSM states IDLE and RUN; IDLE->RUN when en_i=1; RUN->IDLE only at a frame boundary with en_i=0, so the frame in progress always completes.
REQ-015 In IDLE: sck_o=0, ws_o=0, sd_o=0, divider and bit counter held at 0; holding register still accepts pairs.
REQ-016 In RUN, sck_o toggles every SCK_DIV clk_i cycles, giving an SCK period of 2*SCK_DIV clk_i cycles; first edge is rising, SCK_DIV cycles after entering RUN.
REQ-017 sd_o and ws_o SHALL change only on the clk_i cycle of an SCK falling edge; a receiver samples on SCK rising edges.
REQ-018 Bit counter range 0..2*DATA_W-1, increments on each SCK falling edge and wraps to 0.
REQ-019 Philips I2S timing: ws_o goes to 1 on the falling edge where counter = DATA_W-1 and goes to 0 where counter = 2*DATA_W-1, so WS leads the MSB of each slot by one SCK.
REQ-020 Frame load: on the falling edge where the counter wraps to 0, the 2*DATA_W shift register loads {left,right} from the holding register and sd_o presents left[DATA_W-1]; later falling edges shift one bit each.
REQ-021 The first frame after IDLE->RUN loads on the first SCK falling edge; ws_o is 0 for this partial lead-in.
REQ-022 s_ready_o=0 from acceptance until the frame load that consumes the pair, then 1 on the next cycle.
REQ-023 If acceptance and frame load fall on the same cycle with the register empty, the incoming pair is loaded directly, s_ready_o stays 1, and no underrun is flagged.
REQ-024 Underrun: a frame load with the holding register empty transmits all zeros (see REQ-030) and pulses underrun_o for one cycle.
REQ-025 Latency: a pair accepted at least one cycle before a frame load appears in that frame.

Reset
REQ-026 With rst_i=0 at a clk_i edge: state=IDLE, sck_o=0, ws_o=0, sd_o=0, underrun_o=0, s_ready_o=1, counters, shift and holding registers cleared.
REQ-027 Reset mid-frame aborts immediately; after rst_i=1, the core restarts from IDLE with no partial-frame residue.

Configuration
REQ-028 Macro I2S_TX_UNDERRUN_REPEAT_EN selects underrun behaviour.
REQ-029 Defined: on underrun, the last transmitted pair is resent; underrun_o still pulses.
REQ-030 Undefined: on underrun, zeros are sent.

Structure
REQ-031 Package i2s_pkg SHALL hold the state enum (IDLE, RUN), the WS_LEFT/WS_RIGHT constants and the DATA_W/SCK_DIV range limits.
REQ-032 SCK generation SHALL be one sub-module, i2s_tx_clkgen (divider, sck_o, one-cycle sck_rise/sck_fall strobes).

Verification (DATA_W=16, SCK_DIV=2)
REQ-033 Send pair L=16'hA5C3, R=16'h0F0F, en_i=1 -> first frame sd_o bits A5C3 then 0F0F MSB-first; SCK period 4 clk; ws_o toggles one SCK before each MSB.
REQ-034 Continuous valid stream of 4 pairs -> 4 back-to-back frames of 128 clk each, no underrun_o pulse.
REQ-035 No pair supplied for the second frame -> underrun_o pulses once; zeros sent, or the previous pair when the macro is defined.
REQ-036 en_i deasserted at bit 5 of a frame -> frame completes through bit 31, then IDLE with sck_o=0.
REQ-037 rst_i=0 asserted at bit 20 -> the next cycle shows every output at its reset value; after release with en_i=1, a clean frame starts from bit 0.
